// File: rtl/video_fill_pkg.sv
// Shared types and frame geometry for the rectangle fill engine.
package video_fill_pkg;

  localparam int DEF_H_RES = 640;
  localparam int DEF_V_RES = 480;
  localparam int XW = $clog2(DEF_H_RES);
  localparam int YW = $clog2(DEF_V_RES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/video_rect_fill.sv
// Solid-rectangle fill engine: one Avalon-MM word write per pixel, row-major.
// Define VIDEO_RECT_FILL_CLIP_EN to clip rectangles to the visible frame.
module video_rect_fill
  import video_fill_pkg::*;
#(
  parameter int AVN_AW = 19,
  parameter int AVN_DW = 16,
  parameter int H_RES  = DEF_H_RES,
  parameter int V_RES  = DEF_V_RES
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [XW-1:0]         cmd_x0,
  input  logic [XW-1:0]         cmd_x1,
  input  logic [YW-1:0]         cmd_y0,
  input  logic [YW-1:0]         cmd_y1,
  input  logic [AVN_DW-1:0]     cmd_color,
  output logic                  busy,
  output logic                  done,
  output logic                  framebuffer_avn_write,
  output logic                  framebuffer_avn_read,
  output logic [AVN_AW-1:0]     framebuffer_avn_address,
  output logic [AVN_DW-1:0]     framebuffer_avn_writedata,
  output logic [AVN_DW/8-1:0]   framebuffer_avn_byteenable,
  input  logic                  framebuffer_avn_waitrequest
);

  localparam logic [AVN_AW-1:0] H_STEP = AVN_AW'(H_RES);
`ifdef VIDEO_RECT_FILL_CLIP_EN
  localparam logic [XW-1:0] X_MAX = XW'(H_RES - 1);
  localparam logic [YW-1:0] Y_MAX = YW'(V_RES - 1);
`endif

  state_t              state_q, state_nxt;
  logic [XW-1:0]       x0_q, x1_q, x_q, x0_nxt, x1_nxt, x_nxt;
  logic [YW-1:0]       y0_q, y1_q, y_q, y0_nxt, y1_nxt, y_nxt;
  logic [AVN_AW-1:0]   row_base_q, row_base_nxt, addr_q, addr_nxt;
  logic [AVN_DW-1:0]   color_q, color_nxt;
  logic [AVN_AW-1:0]   base0;
  logic [XW-1:0]       x1_eff;
  logic [YW-1:0]       y1_eff;
  logic                skip;

  assign base0 = AVN_AW'(y0_q) * H_STEP;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q    <= IDLE;
      x0_q       <= '0;
      x1_q       <= '0;
      x_q        <= '0;
      y0_q       <= '0;
      y1_q       <= '0;
      y_q        <= '0;
      row_base_q <= '0;
      addr_q     <= '0;
      color_q    <= '0;
    end else begin
      state_q    <= state_nxt;
      x0_q       <= x0_nxt;
      x1_q       <= x1_nxt;
      x_q        <= x_nxt;
      y0_q       <= y0_nxt;
      y1_q       <= y1_nxt;
      y_q        <= y_nxt;
      row_base_q <= row_base_nxt;
      addr_q     <= addr_nxt;
      color_q    <= color_nxt;
    end
  end

  always_comb begin
    state_nxt    = state_q;
    x0_nxt       = x0_q;
    x1_nxt       = x1_q;
    x_nxt        = x_q;
    y0_nxt       = y0_q;
    y1_nxt       = y1_q;
    y_nxt        = y_q;
    row_base_nxt = row_base_q;
    addr_nxt     = addr_q;
    color_nxt    = color_q;
    x1_eff       = x1_q;
    y1_eff       = y1_q;
    skip         = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          x0_nxt    = cmd_x0;
          x1_nxt    = cmd_x1;
          y0_nxt    = cmd_y0;
          y1_nxt    = cmd_y1;
          color_nxt = cmd_color;
          state_nxt = SETUP;
        end
      end
      SETUP: begin
`ifdef VIDEO_RECT_FILL_CLIP_EN
        if (x1_q > X_MAX) x1_eff = X_MAX;
        if (y1_q > Y_MAX) y1_eff = Y_MAX;
        skip = (x0_q > X_MAX) || (y0_q > Y_MAX);
`endif
        // Store the clamped corner so the WRITE-state end tests see it.
        x1_nxt = x1_eff;
        y1_nxt = y1_eff;
        if (skip || (x0_q > x1_eff) || (y0_q > y1_eff)) begin
          state_nxt = DONE;
        end else begin
          row_base_nxt = base0;
          addr_nxt     = base0 + AVN_AW'(x0_q);
          x_nxt        = x0_q;
          y_nxt        = y0_q;
          state_nxt    = WRITE;
        end
      end
      WRITE: begin
        if (!framebuffer_avn_waitrequest) begin
          if ((x_q == x1_q) && (y_q == y1_q)) begin
            state_nxt = DONE;
          end else if (x_q == x1_q) begin
            x_nxt        = x0_q;
            y_nxt        = y_q + 1'b1;
            row_base_nxt = row_base_q + H_STEP;
            addr_nxt     = row_base_q + H_STEP + AVN_AW'(x0_q);
          end else begin
            x_nxt    = x_q + 1'b1;
            addr_nxt = addr_q + 1'b1;
          end
        end
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign cmd_ready                  = (state_q == IDLE);
  assign busy                       = (state_q != IDLE);
  assign done                       = (state_q == DONE);
  assign framebuffer_avn_write      = (state_q == WRITE);
  assign framebuffer_avn_read       = 1'b0;
  assign framebuffer_avn_address    = addr_q;
  assign framebuffer_avn_writedata  = color_q;
  assign framebuffer_avn_byteenable = '1;

endmodule

// File: tb/tb_video_rect_fill.sv
// Self-checking bench for video_rect_fill: a rectangle-to-pixel-list model feeds a write scoreboard.
module tb_video_rect_fill;
  import video_fill_pkg::*;

  localparam int AW = 19;
  localparam int DW = 16;
  localparam int HR = 640;
  localparam int VR = 480;
  localparam int BUDGET = 20000;

  logic              sys_clk = 1'b0;
  logic              sys_rst = 1'b1;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [XW-1:0]     cmd_x0 = '0, cmd_x1 = '0;
  logic [YW-1:0]     cmd_y0 = '0, cmd_y1 = '0;
  logic [DW-1:0]     cmd_color = '0;
  logic              busy, done;
  logic              fb_write, fb_read;
  logic [AW-1:0]     fb_addr;
  logic [DW-1:0]     fb_wdata;
  logic [DW/8-1:0]   fb_be;
  logic              waitreq = 1'b0;

  video_rect_fill #(.AVN_AW(AW), .AVN_DW(DW), .H_RES(HR), .V_RES(VR)) dut (
    .sys_clk                     (sys_clk),
    .sys_rst                     (sys_rst),
    .cmd_valid                   (cmd_valid),
    .cmd_ready                   (cmd_ready),
    .cmd_x0                      (cmd_x0),
    .cmd_x1                      (cmd_x1),
    .cmd_y0                      (cmd_y0),
    .cmd_y1                      (cmd_y1),
    .cmd_color                   (cmd_color),
    .busy                        (busy),
    .done                        (done),
    .framebuffer_avn_write       (fb_write),
    .framebuffer_avn_read        (fb_read),
    .framebuffer_avn_address     (fb_addr),
    .framebuffer_avn_writedata   (fb_wdata),
    .framebuffer_avn_byteenable  (fb_be),
    .framebuffer_avn_waitrequest (waitreq)
  );

  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  typedef struct { int unsigned addr; int unsigned data; } wr_t;
  wr_t exp_q[$];

  int checks = 0;
  int passes = 0;
  int wr_mode = 0;
  int wcnt = 0;
  int acc_cnt = 0;
  int stall_total = 0;
  int last_acc_cyc = 0;
  bit stall_prev = 1'b0;
  logic [AW-1:0] held_a = '0;
  logic [DW-1:0] held_d = '0;

  function automatic void chk(string name, longint act, longint exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endfunction

  function automatic void fail_now(string name);
    checks++;
    $display("FAIL %s: condition not reached (cycle %0d)", name, cyc);
  endfunction

  // Expected write list: every pixel of the (optionally clipped) rectangle, row-major.
  function automatic int model_rect(int x0, int y0, int x1, int y1, int color);
    int n = 0;
    int xe = x1;
    int ye = y1;
`ifdef VIDEO_RECT_FILL_CLIP_EN
    if (x0 >= HR || y0 >= VR) return 0;
    if (xe > HR - 1) xe = HR - 1;
    if (ye > VR - 1) ye = VR - 1;
`endif
    for (int y = y0; y <= ye; y++)
      for (int x = x0; x <= xe; x++) begin
        wr_t w;
        w.addr = (y * HR + x) & ((1 << AW) - 1);
        w.data = color;
        exp_q.push_back(w);
        n++;
      end
    return n;
  endfunction

  // Slave model and scoreboard share one block so waitrequest and the accept decision agree.
  always @(negedge sys_clk) begin
    if (sys_rst) begin
      waitreq    = 1'b0;
      wcnt       = 0;
      stall_prev = 1'b0;
    end else begin
      if (fb_write) begin
        case (wr_mode)
          0: waitreq = 1'b0;
          1: waitreq = ($urandom_range(0, 2) == 0);
          default: begin
            if (wcnt < 3) begin waitreq = 1'b1; wcnt++; end
            else begin waitreq = 1'b0; wcnt = 0; end
          end
        endcase
      end else begin
        waitreq = 1'b0;
        wcnt    = 0;
      end
      chk("ready_vs_busy", cmd_ready, !busy);
      chk("read_low", fb_read, 0);
      if (stall_prev) begin
        chk("hold_write", fb_write, 1);
        chk("hold_addr", fb_addr, held_a);
        chk("hold_data", fb_wdata, held_d);
      end
      if (fb_write) begin
        if (waitreq) begin
          stall_total++;
          held_a = fb_addr;
          held_d = fb_wdata;
        end else if (exp_q.size() == 0) begin
          fail_now("unexpected_write");
        end else begin
          wr_t w;
          w = exp_q.pop_front();
          chk("write_addr", fb_addr, w.addr);
          chk("write_data", fb_wdata, w.data);
          acc_cnt++;
          last_acc_cyc = cyc;
        end
      end
      stall_prev = fb_write && waitreq;
    end
  end

  // Presents a command, waits for the handshake cycle t; returns at the negedge of cycle t+1.
  task automatic issue(input int x0, input int y0, input int x1, input int y1, input int color,
                       output int t, output int n);
    int k = 0;
    cmd_valid = 1'b1;
    cmd_x0 = XW'(x0); cmd_x1 = XW'(x1);
    cmd_y0 = YW'(y0); cmd_y1 = YW'(y1);
    cmd_color = DW'(color);
    while (!cmd_ready && k < BUDGET) begin @(negedge sys_clk); k++; end
    if (!cmd_ready) fail_now("accept_timeout");
    t = cyc;
    acc_cnt = 0;
    stall_total = 0;
    n = model_rect(x0, y0, x1, y1, color);
    @(negedge sys_clk);
  endtask

  // Follows a command through to done; garbage keeps cmd_valid high with changing fields.
  task automatic finish(input int t, input int n, input bit garbage, output int done_cyc);
    int k = 0;
    if (!garbage) cmd_valid = 1'b0;
    chk("setup_ready", cmd_ready, 0);
    chk("setup_busy", busy, 1);
    chk("setup_write", fb_write, 0);
    while (!done && k < BUDGET) begin
      @(negedge sys_clk);
      k++;
      if (garbage) begin
        cmd_x0 = XW'($urandom); cmd_x1 = XW'($urandom);
        cmd_y0 = YW'($urandom); cmd_y1 = YW'($urandom);
        cmd_color = DW'($urandom);
      end
      if (cyc == t + 2) chk("first_write", fb_write, (n > 0) ? 1 : 0);
    end
    done_cyc = cyc;
    if (!done) begin
      fail_now("done_timeout");
      return;
    end
    chk("done_cycle", cyc, (n > 0) ? last_acc_cyc + 1 : t + 2);
    chk("done_latency", cyc, t + 2 + n + stall_total);
    chk("accept_count", acc_cnt, n);
    chk("queue_empty", exp_q.size(), 0);
    chk("done_write_low", fb_write, 0);
    @(negedge sys_clk);
    chk("done_pulse", done, 0);
    chk("ready_after", cmd_ready, 1);
  endtask

  task automatic run(input int x0, input int y0, input int x1, input int y1, input int color);
    int t, n, d;
    issue(x0, y0, x1, y1, color, t, n);
    finish(t, n, 1'b0, d);
  endtask

  initial begin
    int t, n, d, t2, n2, k;
    repeat (2) @(negedge sys_clk);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_write", fb_write, 0);
    chk("rst_addr", fb_addr, 0);
    chk("rst_wdata", fb_wdata, 0);
    chk("byteenable", fb_be, 3);
    sys_rst = 1'b0;
    @(negedge sys_clk);

    // Small rectangle, no stalls; the model itself is pinned against hand values.
    wr_mode = 0;
    issue(2, 3, 4, 4, 16'hF800, t, n);
    chk("model_t1_count", exp_q.size(), 6);
    chk("model_t1_first", exp_q[0].addr, 1922);
    chk("model_t1_row2", exp_q[3].addr, 2562);
    chk("model_t1_last", exp_q[5].addr, 2564);
    finish(t, n, 1'b0, d);
    chk("t1_latency", d, t + 8);

    // Same rectangle, three stall cycles per write.
    wr_mode = 2;
    issue(2, 3, 4, 4, 16'hF800, t, n);
    finish(t, n, 1'b0, d);
    chk("t2_latency", d, t + 2 + 6 * 4);
    wr_mode = 0;

    // Single pixel, then an empty rectangle.
    issue(5, 5, 5, 5, 16'h1234, t, n);
    chk("model_t3_count", exp_q.size(), 1);
    chk("model_t3_addr", exp_q[0].addr, 3205);
    finish(t, n, 1'b0, d);
    issue(7, 1, 3, 1, 16'h5555, t, n);
    chk("model_empty", n, 0);
    finish(t, n, 1'b0, d);
    chk("empty_done_t2", d, t + 2);

    // Rectangle crossing the frame edge.
    issue(638, 479, 700, 500, 16'h07E0, t, n);
`ifdef VIDEO_RECT_FILL_CLIP_EN
    chk("model_t4_count", exp_q.size(), 2);
    chk("model_t4_last", exp_q[1].addr, 307199);
`else
    chk("model_t4_count", exp_q.size(), 63 * 22);
    chk("model_t4_last", exp_q[63 * 22 - 1].addr, 320700);
`endif
    chk("model_t4_first", exp_q[0].addr, 307198);
    finish(t, n, 1'b0, d);

    // Reset while the third write of the first test is presented.
    issue(2, 3, 4, 4, 16'hF800, t, n);
    cmd_valid = 1'b0;
    k = 0;
    while (!(acc_cnt == 3 && fb_write) && k < 100) begin @(negedge sys_clk); #1; k++; end
    if (!(acc_cnt == 3 && fb_write)) fail_now("third_write_reach");
    #1 sys_rst = 1'b1;
    #1;
    chk("mid_rst_write", fb_write, 0);
    chk("mid_rst_ready", cmd_ready, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_addr", fb_addr, 0);
    exp_q.delete();
    @(negedge sys_clk);
    sys_rst = 1'b0;
    @(negedge sys_clk);
    run(10, 20, 12, 21, 16'hABCD);

    // cmd_valid held high while busy: the second command waits for cmd_ready.
    issue(100, 50, 103, 51, 16'h00FF, t, n);
    finish(t, n, 1'b1, d);
    issue(200, 60, 201, 62, 16'hFF00, t2, n2);
    chk("second_accept_cycle", t2, d + 1);
    finish(t2, n2, 1'b0, d);

    // Randomized rectangles with random stalls.
    for (int i = 0; i < 25; i++) begin
      int x0, y0;
      x0 = int'($urandom_range(1, 630));
      y0 = int'($urandom_range(1, 470));
      wr_mode = int'($urandom_range(0, 1));
      run(x0, y0, x0 + int'($urandom_range(0, 6)) - 1, y0 + int'($urandom_range(0, 3)) - 1,
          int'($urandom_range(0, 65535)));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
